// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard sequencer.
// Holds the FSM state encoding, per-cycle action encoding and the saturating counter step.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FREEZE
  } hazard_state_t;

  // One action is chosen per cycle; it drives both the outputs and the next-state update.
  typedef enum logic [2:0] {
    ACT_FREEZE,
    ACT_BRANCH,
    ACT_STALL,
    ACT_JUMP,
    ACT_LOAD_USE,
    ACT_NONE
  } hazard_action_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Increment that sticks at the all-ones value of a counter 'width' bits wide (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the load in EX writes a register the ID instruction reads.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rt,
  input  logic       ex_mem_read,
  output logic       load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_uses_rs && (ex_rt == id_rs);
  assign rt_match = id_uses_rt && (ex_rt == id_rt);

  // Register zero is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_controller.sv
// Hazard sequencer for the 5-stage core: load-use bubbles, branch/jump squash, memory-wait freeze.
// Control outputs are combinational from state and inputs; counters are registered and saturate.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             hazard_source,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_USE_STALLS - 1);

  hazard_state_t  state;
  hazard_state_t  resume_state;
  hazard_state_t  eval_state;
  hazard_action_t action;
  logic [2:0]     stall_left;
  logic           pend_flush;
  logic           load_use;
  logic           branch;

  load_use_detect u_load_use_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_rt       (ex_rt),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // Leaving a freeze, the cycle behaves as whichever state was interrupted.
  assign eval_state = (state == FREEZE) ? resume_state : state;
  assign branch     = ex_branch_taken || pend_flush;

  always_comb begin
    action = ACT_NONE;
    if (mem_busy) begin
      action = ACT_FREEZE;
    end else if (branch) begin
      action = ACT_BRANCH;
    end else if (eval_state == STALL) begin
      action = ACT_STALL;
    end else if (id_jump) begin
      action = ACT_JUMP;
    end else if (load_use) begin
      action = ACT_LOAD_USE;
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    hazard_source = 1'b0;
    pipe_hold     = 1'b0;
    if (rst) begin
      pc_write      = 1'b0;
      ifid_write    = 1'b0;
      hazard_source = 1'b1;
      pipe_hold     = 1'b1;
    end else begin
      case (action)
        ACT_FREEZE: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
        end
        ACT_BRANCH: begin
          ifid_flush    = 1'b1;
          hazard_source = 1'b1;
        end
        ACT_JUMP: begin
          ifid_flush = 1'b1;
        end
        ACT_STALL, ACT_LOAD_USE: begin
          pc_write      = 1'b0;
          ifid_write    = 1'b0;
          hazard_source = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // FSM, bubble down-counter, deferred branch flag and event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      resume_state <= RUN;
      stall_left   <= 3'd0;
      pend_flush   <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      freeze_cnt   <= '0;
    end else begin
      case (action)
        ACT_FREEZE: begin
          if (state != FREEZE) begin
            resume_state <= state;
          end
          state      <= FREEZE;
          pend_flush <= pend_flush || ex_branch_taken;
          freeze_cnt <= CNT_W'(sat_inc(32'(freeze_cnt), CNT_W));
        end
        ACT_BRANCH: begin
          state      <= RUN;
          pend_flush <= 1'b0;
          stall_left <= 3'd0;
          flush_cnt  <= CNT_W'(sat_inc(32'(flush_cnt), CNT_W));
        end
        ACT_STALL: begin
          stall_cnt <= CNT_W'(sat_inc(32'(stall_cnt), CNT_W));
          if (stall_left <= 3'd1) begin
            state      <= RUN;
            stall_left <= 3'd0;
          end else begin
            state      <= STALL;
            stall_left <= stall_left - 3'd1;
          end
        end
        ACT_JUMP: begin
          state     <= RUN;
          flush_cnt <= CNT_W'(sat_inc(32'(flush_cnt), CNT_W));
        end
        ACT_LOAD_USE: begin
          stall_cnt <= CNT_W'(sat_inc(32'(stall_cnt), CNT_W));
          if (LOAD_USE_STALLS == 1) begin
            state <= RUN;
          end else begin
            state      <= STALL;
            stall_left <= STALL_RELOAD;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench: two hazard_controller instances (1 and 3 load-use bubbles) share directed stimulus.
// A cycle-level reference model checks every output each cycle; literal checks pin the model.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_uses_rs = 1'b0;
  logic       id_uses_rt = 1'b0;
  logic [4:0] ex_rt = '0;
  logic       ex_mem_read = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       id_jump = 1'b0;
  logic       mem_busy = 1'b0;

  logic        a_pc_write, a_ifid_write, a_ifid_flush, a_hazard_source, a_pipe_hold;
  logic [15:0] a_stall_cnt, a_flush_cnt, a_freeze_cnt;
  logic        b_pc_write, b_ifid_write, b_ifid_flush, b_hazard_source, b_pipe_hold;
  logic [3:0]  b_stall_cnt, b_flush_cnt, b_freeze_cnt;

  int assertions = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_USE_STALLS(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .mem_busy(mem_busy),
    .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
    .hazard_source(a_hazard_source), .pipe_hold(a_pipe_hold),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .freeze_cnt(a_freeze_cnt)
  );

  hazard_controller #(.LOAD_USE_STALLS(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .mem_busy(mem_busy),
    .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
    .hazard_source(b_hazard_source), .pipe_hold(b_pipe_hold),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .freeze_cnt(b_freeze_cnt)
  );

  // Output views indexed by instance: flags are {pc_write, ifid_write, ifid_flush, hazard_source, pipe_hold}.
  logic [4:0]  got_flags [2];
  logic [31:0] got_cnt   [2][3];
  assign got_flags[0] = {a_pc_write, a_ifid_write, a_ifid_flush, a_hazard_source, a_pipe_hold};
  assign got_flags[1] = {b_pc_write, b_ifid_write, b_ifid_flush, b_hazard_source, b_pipe_hold};
  assign got_cnt[0][0] = 32'(a_stall_cnt);
  assign got_cnt[0][1] = 32'(a_flush_cnt);
  assign got_cnt[0][2] = 32'(a_freeze_cnt);
  assign got_cnt[1][0] = 32'(b_stall_cnt);
  assign got_cnt[1][1] = 32'(b_flush_cnt);
  assign got_cnt[1][2] = 32'(b_freeze_cnt);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: bubbles still owed, a branch remembered across a freeze, and event tallies.
  int  lus [2] = '{1, 3};
  int  cmax[2] = '{65535, 15};
  int  m_bubbles[2];
  bit  m_pend[2];
  int  m_cnt[2][3];
  logic [4:0] exp_flags;
  bit  m_lu;
  string flag_names[5] = '{"pc_write", "ifid_write", "ifid_flush", "hazard_source", "pipe_hold"};
  string cnt_names[3]  = '{"stall_cnt", "flush_cnt", "freeze_cnt"};

  function automatic int bump(input int value, input int limit);
    return (value < limit) ? value + 1 : limit;
  endfunction

  always @(negedge clk) begin
    m_lu = ex_mem_read && (ex_rt != 5'd0) &&
           ((id_uses_rs && ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_bubbles[k] = 0;
        m_pend[k]    = 1'b0;
        for (int i = 0; i < 3; i++) m_cnt[k][i] = 0;
        exp_flags = 5'b00011;
      end else if (mem_busy) begin
        exp_flags = 5'b00001;
      end else if (ex_branch_taken || m_pend[k]) begin
        exp_flags = 5'b11110;
      end else if (m_bubbles[k] > 0) begin
        exp_flags = 5'b00010;
      end else if (id_jump) begin
        exp_flags = 5'b11100;
      end else if (m_lu) begin
        exp_flags = 5'b00010;
      end else begin
        exp_flags = 5'b11000;
      end

      for (int i = 0; i < 5; i++) begin
        if (!(i == 1 && exp_flags[2])) begin
          checkOutput($sformatf("dut%0d.%s", k, flag_names[i]),
                      32'(got_flags[k][4-i]), 32'(exp_flags[4-i]));
        end
      end
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("dut%0d.%s", k, cnt_names[i]), got_cnt[k][i], 32'(m_cnt[k][i]));
      end

      if (!rst) begin
        if (mem_busy) begin
          m_pend[k]   = m_pend[k] || ex_branch_taken;
          m_cnt[k][2] = bump(m_cnt[k][2], cmax[k]);
        end else if (ex_branch_taken || m_pend[k]) begin
          m_pend[k]    = 1'b0;
          m_bubbles[k] = 0;
          m_cnt[k][1]  = bump(m_cnt[k][1], cmax[k]);
        end else if (m_bubbles[k] > 0) begin
          m_bubbles[k]--;
          m_cnt[k][0] = bump(m_cnt[k][0], cmax[k]);
        end else if (id_jump) begin
          m_cnt[k][1] = bump(m_cnt[k][1], cmax[k]);
        end else if (m_lu) begin
          m_bubbles[k] = lus[k] - 1;
          m_cnt[k][0]  = bump(m_cnt[k][0], cmax[k]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [4:0] f_rs, input logic [4:0] f_rt, input logic [4:0] f_ex_rt,
                               input logic f_urs, input logic f_urt, input logic f_mr,
                               input logic f_br, input logic f_jp, input logic f_mb);
    @(posedge clk);
    #1;
    id_rs = f_rs; id_rt = f_rt; ex_rt = f_ex_rt;
    id_uses_rs = f_urs; id_uses_rt = f_urt; ex_mem_read = f_mr;
    ex_branch_taken = f_br; id_jump = f_jp; mem_busy = f_mb;
  endtask

  task automatic idleCycle();
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic loadUseCycle(input logic f_br, input logic f_jp, input logic f_mb);
    applyStimulus(5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, f_br, f_jp, f_mb);
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; id_jump = 1'b0; mem_busy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset with hazards present on every input: outputs forced regardless.
    applyStimulus(5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    checkOutput("rst a.hazard_source", 32'(a_hazard_source), 32'd1);
    checkOutput("rst a.pc_write", 32'(a_pc_write), 32'd0);
    checkOutput("rst a.pipe_hold", 32'(a_pipe_hold), 32'd1);
    checkOutput("rst b.pipe_hold", 32'(b_pipe_hold), 32'd1);
    idleCycle();
    rst = 1'b0;
    #2;
    checkOutput("release a.pc_write", 32'(a_pc_write), 32'd1);
    checkOutput("release a.stall_cnt", 32'(a_stall_cnt), 32'd0);
    checkOutput("release b.freeze_cnt", 32'(b_freeze_cnt), 32'd0);

    // Load-use through rs: one bubble on A, three on B.
    loadUseCycle(1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("lu a.pc_write", 32'(a_pc_write), 32'd0);
    checkOutput("lu a.hazard_source", 32'(a_hazard_source), 32'd1);
    idleCycle();
    #2;
    checkOutput("lu+1 a.pc_write", 32'(a_pc_write), 32'd1);
    checkOutput("lu+1 a.stall_cnt", 32'(a_stall_cnt), 32'd1);
    checkOutput("lu+1 b.pc_write", 32'(b_pc_write), 32'd0);
    idleCycle();
    #2;
    checkOutput("lu+2 b.pc_write", 32'(b_pc_write), 32'd0);
    idleCycle();
    #2;
    checkOutput("lu+3 b.pc_write", 32'(b_pc_write), 32'd1);
    checkOutput("lu+3 b.stall_cnt", 32'(b_stall_cnt), 32'd3);

    // Load to register zero never stalls.
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("r0 a.pc_write", 32'(a_pc_write), 32'd1);
    checkOutput("r0 a.hazard_source", 32'(a_hazard_source), 32'd0);
    idleCycle();
    #2;
    checkOutput("r0 a.stall_cnt", 32'(a_stall_cnt), 32'd1);

    // Match through rt, then a match on an unused rs.
    applyStimulus(5'd3, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("rt a.pc_write", 32'(a_pc_write), 32'd0);
    idleCycle();
    idleCycle();
    applyStimulus(5'd8, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("unused rs a.pc_write", 32'(a_pc_write), 32'd1);
    checkOutput("rt b.stall_cnt", 32'(b_stall_cnt), 32'd6);

    // Reset in the middle of a multi-cycle stall discards it.
    loadUseCycle(1'b0, 1'b0, 1'b0);
    resetDut();
    #2;
    checkOutput("mid-stall rst b.pc_write", 32'(b_pc_write), 32'd1);
    checkOutput("mid-stall rst b.stall_cnt", 32'(b_stall_cnt), 32'd0);

    // Branch coincident with load-use wins; jump beats load-use without a bubble.
    resetDut();
    loadUseCycle(1'b1, 1'b0, 1'b0);
    #2;
    checkOutput("br a.ifid_flush", 32'(a_ifid_flush), 32'd1);
    checkOutput("br a.hazard_source", 32'(a_hazard_source), 32'd1);
    checkOutput("br b.pc_write", 32'(b_pc_write), 32'd1);
    idleCycle();
    #2;
    checkOutput("br+1 b.pc_write", 32'(b_pc_write), 32'd1);
    checkOutput("br+1 a.flush_cnt", 32'(a_flush_cnt), 32'd1);
    checkOutput("br+1 b.stall_cnt", 32'(b_stall_cnt), 32'd0);
    loadUseCycle(1'b0, 1'b1, 1'b0);
    #2;
    checkOutput("jmp a.ifid_flush", 32'(a_ifid_flush), 32'd1);
    checkOutput("jmp a.hazard_source", 32'(a_hazard_source), 32'd0);
    idleCycle();
    #2;
    checkOutput("jmp+1 a.flush_cnt", 32'(a_flush_cnt), 32'd2);
    checkOutput("jmp+1 a.stall_cnt", 32'(a_stall_cnt), 32'd0);

    // Branch pulse during a 4-cycle memory wait is replayed on release.
    resetDut();
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    checkOutput("frz a.pipe_hold", 32'(a_pipe_hold), 32'd1);
    checkOutput("frz a.ifid_flush", 32'(a_ifid_flush), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idleCycle();
    #2;
    checkOutput("frz rel a.ifid_flush", 32'(a_ifid_flush), 32'd1);
    checkOutput("frz rel a.freeze_cnt", 32'(a_freeze_cnt), 32'd4);
    idleCycle();
    #2;
    checkOutput("frz rel+1 a.flush_cnt", 32'(a_flush_cnt), 32'd1);
    checkOutput("frz rel+1 a.ifid_flush", 32'(a_ifid_flush), 32'd0);

    // Freeze inside a 3-bubble stall: stall resumes with its remaining count.
    resetDut();
    loadUseCycle(1'b0, 1'b0, 1'b0);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    checkOutput("stfrz b.pipe_hold", 32'(b_pipe_hold), 32'd1);
    checkOutput("stfrz b.hazard_source", 32'(b_hazard_source), 32'd0);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idleCycle();
    #2;
    checkOutput("stfrz resume b.pc_write", 32'(b_pc_write), 32'd0);
    idleCycle();
    idleCycle();
    #2;
    checkOutput("stfrz end b.pc_write", 32'(b_pc_write), 32'd1);
    checkOutput("stfrz end b.stall_cnt", 32'(b_stall_cnt), 32'd3);
    checkOutput("stfrz end b.freeze_cnt", 32'(b_freeze_cnt), 32'd2);

    // Drive counters past all-ones on the 4-bit instance.
    for (int i = 0; i < 20; i++) applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idleCycle();
    #2;
    checkOutput("sat b.freeze_cnt", 32'(b_freeze_cnt), 32'd15);
    checkOutput("sat a.freeze_cnt", 32'(a_freeze_cnt), 32'd22);
    for (int i = 0; i < 6; i++) begin
      loadUseCycle(1'b0, 1'b0, 1'b0);
      idleCycle();
      idleCycle();
    end
    idleCycle();
    #2;
    checkOutput("sat b.stall_cnt", 32'(b_stall_cnt), 32'd15);
    checkOutput("sat a.stall_cnt", 32'(a_stall_cnt), 32'd7);
    for (int i = 0; i < 16; i++) applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycle();
    #2;
    checkOutput("sat b.flush_cnt", 32'(b_flush_cnt), 32'd15);
    checkOutput("sat a.flush_cnt", 32'(a_flush_cnt), 32'd16);
    idleCycle();
    idleCycle();
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
